// File: rtl/noc_pe_if_pkg.sv
// rtl/noc_pe_if_pkg.sv - Shared flit field positions, counter width and helpers for noc_pe_if
//
// Contents:
//   ADDR_MSB / ADDR_LSB : destination address field within a flit
//   PAYLOAD_W           : payload width (flit bits below the address field)
//   ADDR_W, FLIT_W      : derived field widths
//   DROP_CNT_W          : width of the misaddressed-flit drop counter
//   sat_inc()           : saturating increment for the drop counter
package noc_pe_if_pkg;

    localparam int ADDR_MSB   = 31;
    localparam int ADDR_LSB   = 24;
    localparam int PAYLOAD_W  = 24;
    localparam int ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
    localparam int FLIT_W     = ADDR_W + PAYLOAD_W;
    localparam int DROP_CNT_W = 16;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/noc_pe_if_fifo.sv
// rtl/noc_pe_if_fifo.sv - Synchronous valid/ready FIFO used for the TX and RX paths
//
// Parameters:
//   Width : entry width
//   Depth : number of entries, power of two, >= 2
// Ports:
//   i_clk, i_reset_n           : clock, asynchronous active-low reset
//   i_wr_data/valid, o_wr_ready: write side handshake
//   o_rd_data/valid, i_rd_ready: read side handshake (o_rd_data is the head entry)
module noc_sync_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [Width-1:0] i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [Width-1:0] o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready
);

    localparam int AW = $clog2(Depth);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             ready_en;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [Width-1:0] mem [Depth];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // ready_en keeps the write side closed until the first edge after reset release.
    // Ready depends only on registered state, so a full FIFO refuses a push even
    // when a pop happens on the same edge.
    assign o_wr_ready = ready_en & ~full;
    assign o_rd_valid = ~empty;
    assign o_rd_data  = mem[rd_ptr[AW-1:0]];

    assign push = i_wr_valid & o_wr_ready;
    assign pop  = o_rd_valid & i_rd_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; entries are only observable once written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/noc_pe_if.sv
// rtl/noc_pe_if.sv - Processing-element to NoC leaf-port interface with TX/RX buffering
//
// Parameters:
//   DataWidth : flit width (32 only; [31:24] destination, [23:0] payload)
//   MyAddr    : 8-bit address of the attached PE
//   TxDepth   : TX FIFO entries (power of two, >= 2)
//   RxDepth   : RX FIFO entries (power of two, >= 2)
// Ports:
//   i_clk, i_reset_n                     : clock, asynchronous active-low reset
//   i_pe_data/dest/valid, o_pe_ready     : PE TX beat in
//   o_data/o_data_valid, i_data_ready    : flit out to switch
//   i_data/i_data_valid, o_data_ready    : flit in from switch
//   o_pe_data/o_pe_valid, i_pe_ready     : PE RX payload out
//   o_drop_count                         : saturating count of misaddressed flits dropped
module noc_pe_if
    import noc_pe_if_pkg::*;
#(
    parameter int         DataWidth = 32,
    parameter logic [7:0] MyAddr    = 8'h00,
    parameter int         TxDepth   = 4,
    parameter int         RxDepth   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [PAYLOAD_W-1:0]  i_pe_data,
    input  logic [ADDR_W-1:0]     i_pe_dest,
    input  logic                  i_pe_valid,
    output logic                  o_pe_ready,
    output logic [DataWidth-1:0]  o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    input  logic [DataWidth-1:0]  i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [PAYLOAD_W-1:0]  o_pe_data,
    output logic                  o_pe_valid,
    input  logic                  i_pe_ready,
    output logic [DROP_CNT_W-1:0] o_drop_count
);

    logic                  addr_match;
    logic                  rx_wr_ready;
    logic [DROP_CNT_W-1:0] drop_count;

    // TX: PE beats are packed into flits; traffic addressed to ourselves still goes out.
    noc_sync_fifo #(
        .Width (DataWidth),
        .Depth (TxDepth)
    ) u_tx_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr_data  ({i_pe_dest, i_pe_data}),
        .i_wr_valid (i_pe_valid),
        .o_wr_ready (o_pe_ready),
        .o_rd_data  (o_data),
        .o_rd_valid (o_data_valid),
        .i_rd_ready (i_data_ready)
    );

    // RX: ready reflects only FIFO space, so a misaddressed flit is consumed
    // (and counted) only when a well-addressed one could have been stored too.
    assign addr_match   = (i_data[ADDR_MSB:ADDR_LSB] == MyAddr);
    assign o_data_ready = rx_wr_ready;

    noc_sync_fifo #(
        .Width (PAYLOAD_W),
        .Depth (RxDepth)
    ) u_rx_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr_data  (i_data[PAYLOAD_W-1:0]),
        .i_wr_valid (i_data_valid & addr_match),
        .o_wr_ready (rx_wr_ready),
        .o_rd_data  (o_pe_data),
        .o_rd_valid (o_pe_valid),
        .i_rd_ready (i_pe_ready)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drop_count <= '0;
        end else if (i_data_valid && rx_wr_ready && !addr_match) begin
            drop_count <= sat_inc(drop_count);
        end
    end

    assign o_drop_count = drop_count;

endmodule

// File: tb/tb_noc_pe_if.sv
// tb/tb_noc_pe_if.sv - Self-checking bench for noc_pe_if
module tb_noc_pe_if;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [23:0] i_pe_data;
    logic [7:0]  i_pe_dest;
    logic        i_pe_valid;
    logic        o_pe_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [23:0] o_pe_data;
    logic        o_pe_valid;
    logic        i_pe_ready;
    logic [15:0] o_drop_count;

    always #5 i_clk = ~i_clk;

    noc_pe_if #(
        .DataWidth (32),
        .MyAddr    (8'h03),
        .TxDepth   (4),
        .RxDepth   (2)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_pe_data    (i_pe_data),
        .i_pe_dest    (i_pe_dest),
        .i_pe_valid   (i_pe_valid),
        .o_pe_ready   (o_pe_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_pe_data    (o_pe_data),
        .o_pe_valid   (o_pe_valid),
        .i_pe_ready   (i_pe_ready),
        .o_drop_count (o_drop_count)
    );

    int tests_run = 0;
    int fails     = 0;
    logic [15:0] drop_exp;

    typedef struct {
        logic [31:0] flit;
        logic        accept;
        logic [23:0] payload;
    } rx_vec_t;

    rx_vec_t rx_tab[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_pe_data    = '0;
        i_pe_dest    = '0;
        i_pe_valid   = 1'b0;
        i_data_ready = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_pe_ready   = 1'b0;
    endtask

    // Leaves the bench at the negedge where reset is released.
    task automatic do_reset();
        i_reset_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic txf;
        int   got;
        int   pushed;
        int   gaps;
        int   cyc;
        bit   started;

        rx_tab[0] = '{32'h03ABCDEF, 1'b1, 24'hABCDEF};
        rx_tab[1] = '{32'h07000000, 1'b0, 24'h000000};
        rx_tab[2] = '{32'h03123456, 1'b1, 24'h123456};
        rx_tab[3] = '{32'hFF000001, 1'b0, 24'h000000};
        rx_tab[4] = '{32'h00000003, 1'b0, 24'h000000};
        rx_tab[5] = '{32'h03FFFFFF, 1'b1, 24'hFFFFFF};
        rx_tab[6] = '{32'h02FFFFFF, 1'b0, 24'h000000};

        // Reset state, asserted away from any edge
        i_reset_n = 1'b0;
        drive_idle();
        #12;
        check("rst_pe_ready",   o_pe_ready,   0);
        check("rst_data_ready", o_data_ready, 0);
        check("rst_data_valid", o_data_valid, 0);
        check("rst_pe_valid",   o_pe_valid,   0);
        check("rst_drop_count", o_drop_count, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        check("rel_pe_ready_low",   o_pe_ready,   0);
        check("rel_data_ready_low", o_data_ready, 0);
        @(negedge i_clk);
        check("rel_pe_ready_high",   o_pe_ready,   1);
        check("rel_data_ready_high", o_data_ready, 1);

        // TX fill with switch stalled
        i_data_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            i_pe_valid = 1'b1;
            i_pe_dest  = 8'h05;
            i_pe_data  = 24'(i);
            @(negedge i_clk);
        end
        check("tx_full_ready", o_pe_ready, 0);
        check("tx_full_valid", o_data_valid, 1);
        // Offer a 5th beat while full and start draining: it must wait for space
        i_pe_data    = 24'd5;
        i_data_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check("tx_drain_valid", o_data_valid, 1);
            check("tx_drain_data",  o_data, {8'h05, 24'(k)});
            if (k == 1) check("tx_full_no_bypass", o_pe_ready, 0);
            txf = i_pe_valid & o_pe_ready;
            @(posedge i_clk);
            #1;
            if (txf) i_pe_valid = 1'b0;
            @(negedge i_clk);
        end
        check("tx_drained", o_data_valid, 0);
        i_data_ready = 1'b0;
        i_pe_valid   = 1'b0;

        // RX address filtering table
        i_pe_ready = 1'b1;
        drop_exp   = '0;
        for (int v = 0; v < 7; v++) begin
            check("rx_ready", o_data_ready, 1);
            i_data       = rx_tab[v].flit;
            i_data_valid = 1'b1;
            @(negedge i_clk);
            i_data_valid = 1'b0;
            if (!rx_tab[v].accept) drop_exp++;
            check("rx_pe_valid", o_pe_valid, rx_tab[v].accept);
            if (rx_tab[v].accept) check("rx_pe_data", o_pe_data, rx_tab[v].payload);
            check("rx_drop_count", o_drop_count, drop_exp);
            @(negedge i_clk);
            check("rx_pe_empty", o_pe_valid, 0);
        end

        // RX full blocks a misaddressed flit
        i_pe_ready   = 1'b0;
        i_data_valid = 1'b1;
        i_data       = 32'h03000011;
        @(negedge i_clk);
        i_data       = 32'h03000022;
        @(negedge i_clk);
        i_data       = 32'h09000000;
        check("rxfull_ready", o_data_ready, 0);
        repeat (2) @(negedge i_clk);
        check("rxfull_drop_blocked", o_drop_count, drop_exp);
        check("rxfull_head", o_pe_data, 24'h000011);
        i_pe_ready = 1'b1;
        @(negedge i_clk);
        check("rxfree_ready", o_data_ready, 1);
        check("rxfree_drop_still", o_drop_count, drop_exp);
        check("rxfree_head", o_pe_data, 24'h000022);
        @(negedge i_clk);
        drop_exp++;
        i_data_valid = 1'b0;
        check("rxfree_drop", o_drop_count, drop_exp);
        check("rxfree_empty", o_pe_valid, 0);

        // Continuous TX streaming, 100 beats
        do_reset();
        i_pe_dest    = 8'h05;
        i_pe_data    = '0;
        i_pe_valid   = 1'b1;
        i_data_ready = 1'b1;
        got = 0; pushed = 0; gaps = 0; cyc = 0; started = 1'b0;
        while (got < 100 && cyc < 300) begin
            @(negedge i_clk);
            cyc++;
            txf = i_pe_valid & o_pe_ready;
            if (o_data_valid) begin
                check("stream_data", o_data, {8'h05, 24'(got)});
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            @(posedge i_clk);
            #1;
            if (txf) begin
                pushed++;
                i_pe_data++;
                if (pushed == 100) i_pe_valid = 1'b0;
            end
        end
        check("stream_count", got, 100);
        check("stream_gaps", gaps, 0);
        @(negedge i_clk);
        check("stream_no_extra", o_data_valid, 0);

        // Drop counter saturation
        do_reset();
        i_pe_ready = 1'b1;
        i_data     = 32'h09000000;
        @(negedge i_clk);
        i_data_valid = 1'b1;
        repeat (65534) @(posedge i_clk);
        #1;
        check("drop_fffe", o_drop_count, 16'hFFFE);
        repeat (6) @(posedge i_clk);
        #1;
        check("drop_sat", o_drop_count, 16'hFFFF);
        @(negedge i_clk);
        i_data_valid = 1'b0;

        // Asynchronous reset with buffered TX flits
        do_reset();
        @(negedge i_clk);
        for (int i = 0; i < 3; i++) begin
            i_pe_valid = 1'b1;
            i_pe_dest  = 8'h05;
            i_pe_data  = 24'(16 + i);
            @(negedge i_clk);
        end
        i_pe_valid = 1'b0;
        check("pre_rst_valid", o_data_valid, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_rst_valid", o_data_valid, 0);
        check("async_rst_ready", o_pe_ready, 0);
        @(negedge i_clk);
        i_reset_n    = 1'b1;
        i_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("post_rst_idle", o_data_valid, 0);
        end
        i_pe_valid = 1'b1;
        i_pe_dest  = 8'h0A;
        i_pe_data  = 24'h00ABCD;
        @(negedge i_clk);
        i_pe_valid = 1'b0;
        check("post_rst_new_valid", o_data_valid, 1);
        check("post_rst_new_data",  o_data, 32'h0A00ABCD);
        @(negedge i_clk);
        check("post_rst_new_gone", o_data_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
